// File: rtl/lc3_pkg.sv
// Shared LC-3 constants: opcodes, sequencer state encoding and opcode classification.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_FWAIT  = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_MWAIT  = 4'd6,
        S_WB     = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LD,
        CLS_ST,
        CLS_CTRL,
        CLS_TRAP,
        CLS_ILLEGAL
    } op_class_e;

    // JSR counts as ALU-class: it only needs the R7 write-back.
    function automatic op_class_e classify(input logic [3:0] op);
        classify = CLS_ILLEGAL;
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_LEA, OP_JSR: classify = CLS_ALU;
            OP_LD, OP_LDR:                          classify = CLS_LD;
            OP_ST, OP_STR:                          classify = CLS_ST;
            OP_BR, OP_JMP:                          classify = CLS_CTRL;
            OP_TRAP:                                classify = CLS_TRAP;
            OP_RTI, OP_RES, OP_LDI, OP_STI:         classify = CLS_ILLEGAL;
            default:                                classify = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/lc3_wait_ctr.sv
// Loadable down-counter with zero flag; times the FWAIT and MWAIT memory waits.
module lc3_wait_ctr #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lc3_cycle_ctrl.sv
// LC-3 instruction-cycle sequencer: fetch/decode/execute/memory/write-back phases,
// one instruction in flight, with enables registered alongside the state.
import lc3_pkg::*;

module lc3_cycle_ctrl #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned OP_W        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [15:0]     instr_in,
    output logic [15:0]     ir,
    output logic [OP_W-1:0] opcode_out,
    output logic            imem_en,
    output logic            fetch_start,
    output logic            alu_en,
    output logic            dmem_en,
    output logic            dmem_we,
    output logic            reg_we,
    output logic            nzp_we,
    output logic            halted,
    output logic            illegal,
    output logic [3:0]      state_out
);

    localparam logic [1:0] WAIT_LOAD = 2'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    op_class_e   cls;
    state_e      end_state;
    logic        ctr_load, ctr_zero;
    logic        imem_en_q, fetch_start_q, alu_en_q, dmem_en_q, dmem_we_q;
    logic        reg_we_q, nzp_we_q, halted_q, illegal_q;

    assign cls       = classify(ir_q[15:12]);
    assign end_state = run ? S_FETCH : S_IDLE;
    // MEM also reloads for stores; harmless since stores never enter MWAIT.
    assign ctr_load  = (state_q == S_FETCH) || (state_q == S_MEM);

    lc3_wait_ctr #(.W(2)) u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load),
        .load_val_i (WAIT_LOAD),
        .zero_o     (ctr_zero)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_FWAIT;
            S_FWAIT:  if (ctr_zero) begin
                          ir_d    = instr_in;
                          state_d = S_DECODE;
                      end
            S_DECODE: state_d = (cls == CLS_TRAP || cls == CLS_ILLEGAL) ? S_HALT : S_EXEC;
            S_EXEC:   case (cls)
                          CLS_ALU:        state_d = S_WB;
                          CLS_LD, CLS_ST: state_d = S_MEM;
                          default:        state_d = end_state;
                      endcase
            S_MEM:    state_d = (cls == CLS_LD) ? S_MWAIT : end_state;
            S_MWAIT:  if (ctr_zero) state_d = S_WB;
            S_WB:     state_d = end_state;
            default:  state_d = S_HALT;
        endcase
    end

    // Enables are decoded from the next state so they appear in the same cycle as it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ir_q          <= '0;
            imem_en_q     <= 1'b0;
            fetch_start_q <= 1'b0;
            alu_en_q      <= 1'b0;
            dmem_en_q     <= 1'b0;
            dmem_we_q     <= 1'b0;
            reg_we_q      <= 1'b0;
            nzp_we_q      <= 1'b0;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            imem_en_q     <= (state_d == S_FETCH);
            fetch_start_q <= (state_d == S_DECODE);
            alu_en_q      <= (state_d == S_EXEC);
            dmem_en_q     <= (state_d == S_MEM);
            dmem_we_q     <= (state_d == S_MEM) && (cls == CLS_ST);
            reg_we_q      <= (state_d == S_WB);
            nzp_we_q      <= (state_d == S_WB) && (ir_q[15:12] != OP_JSR);
            halted_q      <= (state_d == S_HALT);
            if (state_q == S_DECODE && cls == CLS_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign ir          = ir_q;
    assign opcode_out  = ir_q[15 -: OP_W];
    assign imem_en     = imem_en_q;
    assign fetch_start = fetch_start_q;
    assign alu_en      = alu_en_q;
    assign dmem_en     = dmem_en_q;
    assign dmem_we     = dmem_we_q;
    assign reg_we      = reg_we_q;
    assign nzp_we      = nzp_we_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_lc3_cycle_ctrl.sv
// Self-checking bench: three sequencers (memory latency 1, 2, 3) driven with directed and
// random instruction streams, compared cycle by cycle against a phase-list reference model.
module tb_lc3_cycle_ctrl;

    logic        clk;
    logic        rst_s   [3];
    logic        run_s   [3];
    logic [15:0] instr_s [3];
    logic [15:0] ir_o    [3];
    logic [3:0]  op_o    [3];
    logic [3:0]  st_o    [3];
    logic        imem_o[3], fs_o[3], alu_o[3], dmem_o[3], we_o[3];
    logic        reg_o[3], nzp_o[3], halt_o[3], ill_o[3];
    logic [15:0] prev_ir [3];

    int n_chk = 0;
    int n_err = 0;
    int cur_dut = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lc3_cycle_ctrl #(.MEM_LATENCY(g + 1), .OP_W(4)) u_dut (
            .clk         (clk),
            .rst         (rst_s[g]),
            .run         (run_s[g]),
            .instr_in    (instr_s[g]),
            .ir          (ir_o[g]),
            .opcode_out  (op_o[g]),
            .imem_en     (imem_o[g]),
            .fetch_start (fs_o[g]),
            .alu_en      (alu_o[g]),
            .dmem_en     (dmem_o[g]),
            .dmem_we     (we_o[g]),
            .reg_we      (reg_o[g]),
            .nzp_we      (nzp_o[g]),
            .halted      (halt_o[g]),
            .illegal     (ill_o[g]),
            .state_out   (st_o[g])
        );
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (L=%0d) got=%h exp=%h", tag, cur_dut + 1, got, exp);
        end
    endtask

    // {imem, fetch_start, alu, dmem_en, dmem_we, reg_we, nzp_we, halted, illegal}
    function automatic logic [8:0] obs_en(input int d);
        return {imem_o[d], fs_o[d], alu_o[d], dmem_o[d], we_o[d],
                reg_o[d], nzp_o[d], halt_o[d], ill_o[d]};
    endfunction

    function automatic logic [8:0] exp_en(input logic [3:0] ph, input logic [3:0] op);
        case (ph)
            4'd1:    return 9'b100000000;
            4'd3:    return 9'b010000000;
            4'd4:    return 9'b001000000;
            4'd5:    return (op == 4'd3 || op == 4'd7) ? 9'b000110000 : 9'b000100000;
            4'd7:    return (op == 4'd4) ? 9'b000001000 : 9'b000001100;
            4'd8:    return (op inside {4'd8, 4'd10, 4'd11, 4'd13}) ? 9'b000000011 : 9'b000000010;
            default: return 9'b000000000;
        endcase
    endfunction

    task automatic do_reset(input int d, input int n);
        rst_s[d] = 1'b1;
        run_s[d] = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            check("rst_state", 16'(st_o[d]), 16'd0);
            check("rst_en", 16'(obs_en(d)), 16'd0);
            check("rst_ir", ir_o[d], 16'h0000);
        end
        rst_s[d] = 1'b0;
        prev_ir[d] = 16'h0000;
    endtask

    // Expects the DUT to enter FETCH on the next edge; leaves it in the same condition
    // unless the instruction halts.
    task automatic do_instr(input int d, input logic [15:0] ins, input bit run_after,
                            input bit rst_in_mwait);
        int          L;
        logic [3:0]  op;
        logic [3:0]  ph[$];
        logic [15:0] exp_ir;
        bit          is_ld, is_st, is_ctl, is_stop;
        L       = d + 1;
        op      = ins[15:12];
        is_ld   = op inside {4'd2, 4'd6};
        is_st   = op inside {4'd3, 4'd7};
        is_ctl  = op inside {4'd0, 4'd12};
        is_stop = op inside {4'd8, 4'd10, 4'd11, 4'd13, 4'd15};
        ph.push_back(4'd1);
        repeat (L) ph.push_back(4'd2);
        ph.push_back(4'd3);
        if (is_stop) begin
            repeat (6) ph.push_back(4'd8);
        end else begin
            ph.push_back(4'd4);
            if (is_ld || is_st) ph.push_back(4'd5);
            if (is_ld) repeat (L) ph.push_back(4'd6);
            if (!is_ctl && !is_st) ph.push_back(4'd7);
        end
        instr_s[d] = ins;
        foreach (ph[i]) begin
            @(posedge clk); #1;
            exp_ir = (i < L + 1) ? prev_ir[d] : ins;
            check("state", 16'(st_o[d]), 16'(ph[i]));
            check("enables", 16'(obs_en(d)), 16'(exp_en(ph[i], op)));
            check("ir", ir_o[d], exp_ir);
            check("opcode", 16'(op_o[d]), 16'(exp_ir[15:12]));
            if (rst_in_mwait && ph[i] == 4'd6) begin
                rst_s[d] = 1'b1;
                run_s[d] = 1'($urandom);
                @(posedge clk); #1;
                check("abort_state", 16'(st_o[d]), 16'd0);
                check("abort_en", 16'(obs_en(d)), 16'd0);
                check("abort_ir", ir_o[d], 16'h0000);
                rst_s[d] = 1'b0;
                run_s[d] = 1'b1;
                prev_ir[d] = 16'h0000;
                return;
            end
            if (i == ph.size() - 1) run_s[d] = run_after;
            else                    run_s[d] = 1'($urandom);
        end
        prev_ir[d] = ins;
        if (is_stop) return;
        if (!run_after) begin
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk); #1;
                check("idle_state", 16'(st_o[d]), 16'd0);
                check("idle_en", 16'(obs_en(d)), 16'd0);
            end
            run_s[d] = 1'b1;
        end
    endtask

    logic [3:0] run_ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd12, 4'd14};

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_s[d]   = 1'b1;
            run_s[d]   = 1'b0;
            instr_s[d] = 16'h0000;
            prev_ir[d] = 16'h0000;
        end
        for (int d = 0; d < 3; d++) begin
            cur_dut = d;
            do_reset(d, 5);
            do_instr(d, 16'h1261, 1'b1, 1'b0);
            do_instr(d, 16'h6A82, 1'b1, 1'b0);
            do_instr(d, 16'h7A82, 1'b1, 1'b0);
            do_instr(d, 16'h1261, 1'b0, 1'b0);
            do_instr(d, 16'h4123, 1'b1, 1'b0);
            for (int k = 0; k < 30; k++) begin
                logic [3:0] op;
                op = run_ops[$urandom_range(0, 10)];
                do_instr(d, {op, 12'($urandom)}, ($urandom_range(0, 9) < 7), 1'b0);
            end
            do_instr(d, 16'h2A05, 1'b1, 1'b1);
            do_instr(d, 16'h5042, 1'b1, 1'b0);
            do_instr(d, 16'hF025, 1'b1, 1'b0);
            do_reset(d, 2);
            do_instr(d, 16'hD123, 1'b1, 1'b0);
            do_reset(d, 2);
            do_instr(d, {4'b1000, 12'($urandom)}, 1'b1, 1'b0);
            do_reset(d, 2);
            do_instr(d, 16'h0E02, 1'b0, 1'b0);
            rst_s[d] = 1'b1;
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lc3_cycle_ctrl.md
Name: lc3_cycle_ctrl

Overview:
- Instruction-cycle sequencer for the LC-3 core.
- Drives the fetch unit's `fetch_start` strobe and the instruction/data memory enables.
- Latches the instruction register and issues per-phase enables (ALU, register write, NZP update) to the datapath.
- Sits between the BRAM instruction/data memories, the fetch unit and the execute datapath; one instruction in flight, no pipelining.

Parameters:
- MEM_LATENCY, 1, BRAM read latency in cycles (legal 1..3); sets the FWAIT and MWAIT lengths.
- OP_W, 4, opcode width; constants live in the shared package.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = sequence instructions, 0 = stop at next instruction boundary
- instr_in  in  16  instruction memory read data
- ir  out  16  latched instruction register
- opcode_out  out  4  ir[15:12], fed to fetch opCode_in
- imem_en  out  1  instruction memory read enable
- fetch_start  out  1  one-cycle pulse; fetch unit updates PC
- alu_en  out  1  execute-stage enable
- dmem_en  out  1  data memory enable
- dmem_we  out  1  data memory write enable
- reg_we  out  1  register file write enable
- nzp_we  out  1  condition-code update enable
- halted  out  1  sticky stop flag
- illegal  out  1  sticky; set when halt was caused by an unsupported opcode
- state_out  out  4  current state encoding, for debug

Behaviour:
- Reset:
  - Sampled on posedge clk while rst=1; takes priority over everything.
  - Next state is IDLE; ir=0; all outputs are 0 (halted and illegal included).
  - A reset mid-instruction aborts it: no enable may be asserted in the cycle after the reset edge.
- State encoding: IDLE=0, FETCH=1, FWAIT=2, DECODE=3, EXEC=4, MEM=5, MWAIT=6, WB=7, HALT=8.
- IDLE: if run=1, go to FETCH.
- FETCH: imem_en=1; load the wait counter with MEM_LATENCY-1; go to FWAIT.
- FWAIT:
  - Hold while the counter is nonzero, decrementing each cycle.
  - At 0: ir <= instr_in and go to DECODE.
  - instr_in is captured exactly MEM_LATENCY cycles after the FETCH cycle.
- DECODE:
  - fetch_start=1 for exactly this one cycle.
  - opcode_out is valid from this cycle onward; the fetch unit resolves BR/JMP/JSR using the NZP value from the previous instruction.
  - Go to EXEC, except TRAP (1111) and unsupported opcodes (RTI 1000, 1101, LDI 1010, STI 1011), which go to HALT. Unsupported opcodes also set illegal.
- EXEC: alu_en=1; next state by opcode:
  - ADD 0001, AND 0101, NOT 1001, LEA 1110, JSR 0100 -> WB.
  - LD 0010, LDR 0110, ST 0011, STR 0111 -> MEM.
  - BR 0000, JMP 1100 -> instruction end.
- MEM:
  - dmem_en=1; dmem_we=1 only for ST/STR.
  - Stores -> instruction end.
  - Loads -> MWAIT, with the counter loaded to MEM_LATENCY-1.
- MWAIT: count down as in FWAIT; at 0 go to WB.
- WB:
  - reg_we=1.
  - nzp_we=1 for ADD, AND, NOT, LEA, LD, LDR; nzp_we=0 for JSR (R7 write only).
  - Then instruction end.
- Instruction end: go to FETCH if run=1, else IDLE. A run drop mid-instruction never truncates the instruction.
- HALT:
  - halted=1; all enables 0.
  - Leave only via rst; run is ignored.
- Enables are Moore outputs, registered with the state.
- dmem_we is never 1 without dmem_en.
- Cycle counts, with L=MEM_LATENCY:
  - ALU-class: 4+L.
  - BR/JMP: 3+L.
  - ST/STR: 4+L.
  - LD/LDR: 5+2L.

Decomposition:
- Package lc3_pkg holds:
  - opcode localparams (OP_BR..OP_TRAP);
  - state encoding constants;
  - a function classifying an opcode into ALU / MEM_LD / MEM_ST / CTRL / TRAP / ILLEGAL.
- One sub-module, lc3_wait_ctr: loadable down-counter with a zero flag, instantiated once and shared by FWAIT and MWAIT.

Test Plan:
- Hold rst=1 for 5 cycles with run=1 -> all outputs 0, state_out=0, no fetch_start. Release rst -> FETCH (state_out=1) on the next edge.
- L=1, instr_in=16'h1261 (ADD) -> ir=16'h1261 in DECODE; fetch_start high exactly 1 cycle; reg_we and nzp_we high in WB; back in FETCH 5 cycles after the first FETCH.
- L=2, LDR 16'h6A82 -> dmem_en=1 with dmem_we=0 in MEM; 2 MWAIT cycles; reg_we in WB; instruction total 9 cycles.
- STR 16'h7A82 -> dmem_en=dmem_we=1 for one cycle; reg_we never asserted; next state FETCH.
- TRAP 16'hF025 -> halted=1 after DECODE and stays 1 with run toggled; illegal=0. Opcode 1101 -> halted=1 and illegal=1.
- Drop run during EXEC of ADD -> WB completes, then IDLE with no further imem_en. rst asserted in MWAIT -> IDLE with all enables 0 on the next cycle.
